// File: rtl/alu_sched_pkg.sv
// Shared types for the ALU scheduler: opcodes, FSM states and field widths.
package alu_sched_pkg;

  localparam int unsigned NREQ    = 2;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned FLAG_W  = 4;
  localparam int unsigned NUM_OPS = 11;

  typedef enum logic [OP_W-1:0] {
    OP_MOV = 4'd0,
    OP_CMP = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd3,
    OP_MUL = 4'd4,
    OP_DIV = 4'd5,
    OP_XOR = 4'd6,
    OP_AND = 4'd7,
    OP_NOT = 4'd8,
    OP_SHL = 4'd9,
    OP_SHR = 4'd10
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_sched_if.sv
// Request, ALU and response signals of the scheduler; slave = scheduler side.
interface alu_sched_if #(parameter int unsigned N = 4);
  import alu_sched_pkg::*;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*N-1:0]      req_a;
  logic [NREQ*N-1:0]      req_b;
  logic [NREQ*OP_W-1:0]   req_op;
  logic [N-1:0]           alu_a;
  logic [N-1:0]           alu_b;
  logic [OP_W-1:0]        alu_select;
  logic [N-1:0]           alu_result;
  logic [FLAG_W-1:0]      alu_flags;
  logic                   resp_valid;
  logic                   resp_ready;
  logic                   resp_id;
  logic [N-1:0]           resp_result;
  logic [FLAG_W-1:0]      resp_flags;
  logic                   resp_err;

  modport slave (
    input  req_valid, req_a, req_b, req_op, alu_result, alu_flags, resp_ready,
    output req_ready, alu_a, alu_b, alu_select,
           resp_valid, resp_id, resp_result, resp_flags, resp_err
  );

  modport master (
    output req_valid, req_a, req_b, req_op, alu_result, alu_flags, resp_ready,
    input  req_ready, alu_a, alu_b, alu_select,
           resp_valid, resp_id, resp_result, resp_flags, resp_err
  );

endinterface

// File: rtl/alu_sched_rr_arb2.sv
// Combinational 2-way round-robin arbiter; a tie goes to the requester
// that did not win last time.
module rr_arb2 (
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic [1:0] grant_c,
  output logic       grant_id_c
);

  always_comb begin
    grant_id_c = 1'b0;
    grant_c    = 2'b00;
    case (req_valid)
      2'b01:   grant_id_c = 1'b0;
      2'b10:   grant_id_c = 1'b1;
      2'b11:   grant_id_c = ~last_grant;
      default: grant_id_c = 1'b0;
    endcase
    if (|req_valid) grant_c = grant_id_c ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one ALU between two requesters.
// Optional ALU_OPCHK_EN: ops >= NUM_OPS bypass the ALU and return resp_err=1.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_sched_if.slave  bus
);

  state_t             state_q, state_d;
  logic               last_q, last_d;
  logic               cur_q, cur_d;
  logic [N-1:0]       a_q, a_d, b_q, b_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic               vld_q, vld_d;
  logic               id_q, id_d;
  logic [N-1:0]       res_q, res_d;
  logic [FLAG_W-1:0]  flg_q, flg_d;
  logic [1:0]         ready_c;
  logic [1:0]         grant_c;
  logic               grant_id_c;
`ifdef ALU_OPCHK_EN
  logic               err_q, err_d;
`endif

  rr_arb2 u_arb (
    .req_valid  (bus.req_valid),
    .last_grant (last_q),
    .grant_c    (grant_c),
    .grant_id_c (grant_id_c)
  );

  // Next-state and datapath capture
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cur_d   = cur_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    vld_d   = vld_q;
    id_d    = id_q;
    res_d   = res_q;
    flg_d   = flg_q;
    ready_c = 2'b00;
`ifdef ALU_OPCHK_EN
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          ready_c = grant_c;
          a_d     = grant_id_c ? bus.req_a[N +: N] : bus.req_a[0 +: N];
          b_d     = grant_id_c ? bus.req_b[N +: N] : bus.req_b[0 +: N];
          op_d    = grant_id_c ? bus.req_op[OP_W +: OP_W] : bus.req_op[0 +: OP_W];
          cur_d   = grant_id_c;
          last_d  = grant_id_c;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d   = bus.alu_result;
        flg_d   = bus.alu_flags;
        id_d    = cur_q;
        vld_d   = 1'b1;
        state_d = RESP;
`ifdef ALU_OPCHK_EN
        err_d   = 1'b0;
        if (op_q >= OP_W'(NUM_OPS)) begin
          res_d = '0;
          flg_d = '0;
          err_d = 1'b1;
        end
`endif
      end
      RESP: begin
        if (bus.resp_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cur_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      vld_q   <= 1'b0;
      id_q    <= 1'b0;
      res_q   <= '0;
      flg_q   <= '0;
`ifdef ALU_OPCHK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cur_q   <= cur_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      vld_q   <= vld_d;
      id_q    <= id_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
`ifdef ALU_OPCHK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Grant is combinational; suppressed while reset is asserted
  assign bus.req_ready   = rst_n ? ready_c : 2'b00;
  assign bus.alu_a       = a_q;
  assign bus.alu_b       = b_q;
  assign bus.alu_select  = op_q;
  assign bus.resp_valid  = vld_q;
  assign bus.resp_id     = id_q;
  assign bus.resp_result = res_q;
  assign bus.resp_flags  = flg_q;
`ifdef ALU_OPCHK_EN
  assign bus.resp_err    = err_q;
`else
  assign bus.resp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sched.sv
// Directed self-checking bench for alu_sched with a small behavioural ALU stub.
module tb_alu_sched;
  import alu_sched_pkg::*;

  localparam int unsigned N = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  alu_sched_if #(.N(N)) bus ();

  alu_sched #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stub: flags = {zero, msb, 2'b01}; unknown ops return 4'hF
  always_comb begin
    case (bus.alu_select)
      4'(OP_ADD): bus.alu_result = bus.alu_a + bus.alu_b;
      4'(OP_SUB): bus.alu_result = bus.alu_a - bus.alu_b;
      4'(OP_XOR): bus.alu_result = bus.alu_a ^ bus.alu_b;
      4'(OP_SHL): bus.alu_result = bus.alu_a << bus.alu_b;
      default:    bus.alu_result = 4'hF;
    endcase
    bus.alu_flags = {(bus.alu_result == 4'h0), bus.alu_result[3], 2'b01};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic req(input int id, input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    bus.req_valid[id]       = 1'b1;
    bus.req_op[id*4 +: 4]   = op;
    bus.req_a[id*N +: N]    = a;
    bus.req_b[id*N +: N]    = b;
  endtask

  task automatic check_resp(input string tag, input logic id, input logic [3:0] res, input logic [3:0] flg);
    check({tag, "_valid"},  32'(bus.resp_valid),  32'd1);
    check({tag, "_id"},     32'(bus.resp_id),     32'(id));
    check({tag, "_result"}, 32'(bus.resp_result), 32'(res));
    check({tag, "_flags"},  32'(bus.resp_flags),  32'(flg));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.req_valid  = 2'b00;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_op     = '0;
    bus.resp_ready = 1'b0;

    // Reset values
    cyc(); cyc();
    settle();
    check("rst_ready",  32'(bus.req_ready),   32'd0);
    check("rst_rvalid", 32'(bus.resp_valid),  32'd0);
    check("rst_id",     32'(bus.resp_id),     32'd0);
    check("rst_result", 32'(bus.resp_result), 32'd0);
    check("rst_flags",  32'(bus.resp_flags),  32'd0);
    check("rst_err",    32'(bus.resp_err),    32'd0);
    check("rst_alu",    32'({bus.alu_a, bus.alu_b, bus.alu_select}), 32'd0);

    // Single ADD on requester 0: latency T, T+1, T+2
    cyc();
    rst_n = 1'b1;
    req(0, 4'(OP_ADD), 4'd3, 4'd5);
    settle();
    check("add_ready", 32'(bus.req_ready), 32'b01);
    cyc();
    bus.req_valid = 2'b00;
    settle();
    check("add_sel",    32'(bus.alu_select), 32'd2);
    check("add_a",      32'(bus.alu_a),      32'd3);
    check("add_b",      32'(bus.alu_b),      32'd5);
    check("add_vld_t1", 32'(bus.resp_valid), 32'd0);
    check("exec_ready", 32'(bus.req_ready),  32'd0);
    cyc();
    settle();
    check_resp("add", 1'b0, 4'd8, 4'b0101);
    bus.resp_ready = 1'b1;
    cyc();
    bus.resp_ready = 1'b0;
    settle();
    check("add_clear",  32'(bus.resp_valid),  32'd0);
    check("add_keep",   32'(bus.resp_result), 32'd8);

    // Tie after reset goes to req0, then req1, then req0 again
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    req(0, 4'(OP_XOR), 4'd6, 4'd3);
    req(1, 4'(OP_SUB), 4'd7, 4'd2);
    bus.resp_ready = 1'b1;
    settle();
    check("tie0_ready", 32'(bus.req_ready), 32'b01);
    cyc();
    bus.req_valid[0] = 1'b0;
    settle();
    check("tie0_sel", 32'(bus.alu_select), 32'd6);
    cyc();
    settle();
    check_resp("tie0", 1'b0, 4'd5, 4'b0001);
    cyc();
    settle();
    check("tie1_ready", 32'(bus.req_ready), 32'b10);
    cyc();
    bus.req_valid[1] = 1'b0;
    cyc();
    settle();
    check_resp("tie1", 1'b1, 4'd5, 4'b0001);
    cyc();
    req(0, 4'(OP_XOR), 4'd6, 4'd3);
    req(1, 4'(OP_SUB), 4'd7, 4'd2);
    settle();
    check("alt_ready", 32'(bus.req_ready), 32'b01);

    // Backpressure in RESP with req1 pending
    bus.resp_ready = 1'b0;
    cyc();
    bus.req_valid[0] = 1'b0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      settle();
      check_resp($sformatf("bp%0d", i), 1'b0, 4'd5, 4'b0001);
      check($sformatf("bp%0d_ready", i), 32'(bus.req_ready), 32'd0);
      cyc();
    end
    bus.resp_ready = 1'b1;
    cyc();
    settle();
    check("bp_clear", 32'(bus.resp_valid), 32'd0);
    check("bp_grant", 32'(bus.req_ready),  32'b10);
    cyc();
    bus.req_valid[1] = 1'b0;
    cyc();
    settle();
    check_resp("bp_req1", 1'b1, 4'd5, 4'b0001);
    cyc();

    // Only req1, back-to-back SHL every 3 cycles
    req(1, 4'(OP_SHL), 4'b0011, 4'd1);
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("shl%0d_grant", i), 32'(bus.req_ready), 32'b10);
      cyc();
      settle();
      check($sformatf("shl%0d_exec", i), 32'(bus.req_ready), 32'd0);
      cyc();
      settle();
      check_resp($sformatf("shl%0d", i), 1'b1, 4'b0110, 4'b0001);
      cyc();
    end
    bus.req_valid = 2'b00;

    // Reset during EXEC discards the operation
    req(0, 4'(OP_ADD), 4'd1, 4'd1);
    cyc();
    bus.req_valid = 2'b00;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    settle();
    check("mid_rvalid", 32'(bus.resp_valid), 32'd0);
    check("mid_ready",  32'(bus.req_ready),  32'd0);
    check("mid_alu",    32'({bus.alu_a, bus.alu_b, bus.alu_select}), 32'd0);
    cyc();
    req(0, 4'(OP_ADD), 4'd1, 4'd1);
    req(1, 4'(OP_SUB), 4'd7, 4'd2);
    settle();
    check("mid_tie", 32'(bus.req_ready), 32'b01);
    cyc();
    bus.req_valid = 2'b00;
    cyc();
    settle();
    check_resp("mid_add", 1'b0, 4'd2, 4'b0001);
    cyc();

    // Illegal opcode 12 on req0
    req(0, 4'd12, 4'd2, 4'd3);
    cyc();
    bus.req_valid = 2'b00;
    settle();
    check("ill_sel", 32'(bus.alu_select), 32'd12);
    cyc();
    settle();
`ifdef ALU_OPCHK_EN
    check_resp("ill", 1'b0, 4'd0, 4'd0);
    check("ill_err", 32'(bus.resp_err), 32'd1);
`else
    check_resp("ill", 1'b0, 4'hF, 4'b0101);
    check("ill_err", 32'(bus.resp_err), 32'd0);
`endif
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_sched.md
Name: alu_sched

Overview:
- Round-robin scheduler that shares one combinational ALU datapath (N-bit a/b, 4-bit op select, N-bit result, 4-bit flags) between two requesters.
- Each requester has a valid/ready request channel. The block has one shared response channel tagged with the requester id.
- Sits between the requesters and the ALU top-level. Drives the ALU operands and select from registered state, and captures the result and flags into a response register.

Parameters:
- N, 4, operand/result width; must match the ALU instance.
- NREQ, 2, number of requesters; fixed at 2 in this revision.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester accept; at most one bit high per cycle
- req_a  in  2*N  operand a; requester i at bits [i*N +: N]
- req_b  in  2*N  operand b, same packing
- req_op  in  8  op select; requester i at bits [i*4 +: 4]
- alu_a  out  N  to ALU a
- alu_b  out  N  to ALU b
- alu_select  out  4  to ALU select
- alu_result  in  N  from ALU result
- alu_flags  in  4  from ALU flags
- resp_valid  out  1  response valid
- resp_ready  in  1  response accept
- resp_id  out  1  requester the response belongs to
- resp_result  out  N  captured result
- resp_flags  out  4  captured flags
- resp_err  out  1  illegal-op indication; tied 0 unless ALU_OPCHK_EN

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - req_ready, resp_valid, resp_id, resp_result, resp_flags, resp_err all 0.
  - alu_a, alu_b, alu_select driven 0.
  - last_grant=1, so requester 0 wins the first tie.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Arbitrates combinationally over req_valid and asserts the winner's req_ready in the same cycle.
  - On that edge: latches the winner's a/b/op into operand registers, sets cur_id=winner and last_grant=winner, then moves to EXEC.
  - If no request is valid: stays in IDLE with req_ready=0.
- Round-robin rule:
  - If both are valid, grant the one not equal to last_grant.
  - If one is valid, grant it regardless of last_grant.
- EXEC:
  - alu_* are driven from the operand registers. They are registered outputs held constant from EXEC through RESP.
  - On the edge: capture alu_result into resp_result and alu_flags into resp_flags, set resp_id=cur_id, set resp_valid=1, move to RESP.
- RESP:
  - Holds resp_* stable while resp_valid=1 and resp_ready=0.
  - On resp_valid and resp_ready: clear resp_valid next cycle and return to IDLE.
  - resp_result, resp_flags and resp_id keep their last values after clearing.
- req_ready is 0 in EXEC and RESP; there is no request buffering.
- Latency: request accepted in cycle T; resp_valid=1 in cycle T+2. Minimum issue interval is 3 cycles.
- Requester contract: req_valid and its payload are held until req_ready. The block samples them only in the accept cycle.
- A requester dropping req_valid before grant is not an error; it is simply not granted.
- Reset mid-operation (EXEC or RESP): the in-flight operation is discarded with no response, and all outputs return to their reset values in the following cycle.
- Arithmetic: none in this block. Result and flags width rules belong to the ALU. The block transports N-bit result and 4-bit flags unmodified.

Optional Feature:
- Macro: ALU_OPCHK_EN
- With the macro: in IDLE, a granted op >= 11 (outside the 11 defined opcodes) is still accepted. In EXEC it sets resp_result=0, resp_flags=0 and resp_err=1, ignoring the ALU. Legal ops set resp_err=0.
- Without the macro: every op is forwarded to the ALU and resp_err is constant 0.

Decomposition:
- Package alu_sched_pkg holds:
  - opcode enum: MOV=0, CMP=1, ADD=2, SUB=3, MUL=4, DIV=5, XOR=6, AND=7, NOT=8, SHL=9, SHR=10
  - NUM_OPS=11
  - state enum {IDLE, EXEC, RESP}
- Sub-module rr_arb2: combinational 2-way round-robin grant from req_valid and last_grant. It is reused later for other shared resources.

Test Plan:
- Reset, then req0: ADD a=3 b=5 in cycle T -> req_ready=2'b01 at T; alu_select=2 and alu_a=3, alu_b=5 at T+1; resp_valid=1, resp_id=0, resp_result=8 and resp_flags=ALU flags at T+2.
- Both valid after reset (req0 XOR 6^3, req1 SUB 7-2) -> req0 granted first with result 5; req1 granted next with result 5; both re-asserted after that -> req0 granted (alternation).
- resp_ready held 0 for 5 cycles in RESP, with a new req1 pending -> resp_* stable throughout, req_ready=0; after the handshake, req1 is granted in the next IDLE cycle.
- Only req1 valid continuously, issuing SHL a=4'b0011 b=1 repeatedly -> req1 granted back to back every 3 cycles, result 4'b0110 each time, no starvation gaps.
- rst_n=0 during EXEC -> next cycle resp_valid=0, req_ready=0, alu_*=0; the first post-reset tie goes to req0.
- req0 op=12 -> with ALU_OPCHK_EN: resp_err=1, result 0, flags 0. Without it: alu_select=12 is forwarded and resp_err=0.
